// File: rtl/dmem_wait_responder_pkg.sv
// ---------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the wait-state data memory responder.
//   state_t  : FSM state encoding (S_IDLE=0, S_WAIT=1, S_DONE=2)
//   CNT_W    : width of the wait-state down-counter (WAIT_CYCLES up to 15)
//   WORD_OFS : number of byte-offset bits below the word index in ADDR
// ---------------------------------------------------------------------------
package dmem_pkg;

  localparam int CNT_W    = 4;
  localparam int WORD_OFS = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_wait_responder_if.sv
// ---------------------------------------------------------------------------
// dmem_wait_responder_if
// M-stage data-port bundle between the pipeline (master) and the memory
// responder (slave).
//   ReqM   : access request                  (master -> slave)
//   WE     : 1 = store, 0 = load             (master -> slave)
//   ADDR   : byte address                    (master -> slave)
//   WD     : store data                      (master -> slave)
//   RD     : load data, held until next done (slave -> master)
//   DoneM  : one-cycle completion pulse      (slave -> master)
//   StallM : pipeline hold request           (slave -> master)
//   Busy   : access in flight                (slave -> master)
//   FaultM : misalignment fault with DoneM   (slave -> master)
// ---------------------------------------------------------------------------
interface dmem_wait_responder_if #(
  parameter int WIDTH = 32
);

  logic             ReqM;
  logic             WE;
  logic [WIDTH-1:0] ADDR;
  logic [WIDTH-1:0] WD;
  logic [WIDTH-1:0] RD;
  logic             DoneM;
  logic             StallM;
  logic             Busy;
  logic             FaultM;

  modport master (
    output ReqM, WE, ADDR, WD,
    input  RD, DoneM, StallM, Busy, FaultM
  );

  modport slave (
    input  ReqM, WE, ADDR, WD,
    output RD, DoneM, StallM, Busy, FaultM
  );

endinterface

// File: rtl/dmem_wait_responder_array.sv
// ---------------------------------------------------------------------------
// dmem_array
// DEPTH x WIDTH word storage with synchronous write and registered read.
// The contents are never cleared; only the read register returns to zero
// on reset.
//   clk    : rising-edge clock
//   reset  : synchronous, active-high (clears rdata only)
//   we     : write enable
//   waddr  : write word index
//   wdata  : write data
//   re     : read enable; rdata updates on the next edge
//   raddr  : read word index
//   rdata  : registered read data, holds between reads
// ---------------------------------------------------------------------------
module dmem_array #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  // Storage write port: contents survive reset, so no reset branch here.
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  // Registered read port: the value is kept until the next read so the
  // responder can present stable load data after completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdata <= '0;
    end else if (re) begin
      r_rdata <= r_mem[raddr];
    end
  end

  assign rdata = r_rdata;

endmodule

// File: rtl/dmem_wait_responder.sv
// ---------------------------------------------------------------------------
// dmem_wait_responder
// Memory-side responder for the M-stage data port. Accepts one load/store
// from IDLE, spends WAIT_CYCLES cycles in WAIT, then pulses DoneM for one
// cycle in DONE. StallM holds the pipeline from the first request cycle
// until the done cycle.
//   clk    : rising-edge clock
//   reset  : synchronous, active-high; aborts any access in flight
//   bus    : dmem_wait_responder_if.slave (ReqM/WE/ADDR/WD in,
//            RD/DoneM/StallM/Busy/FaultM out)
// Optional feature macro: DMEM_MISALIGN_FAULT_EN
//   defined   -> ADDR[1:0]!=0 at accept suppresses the store, forces RD=0
//                and raises FaultM with DoneM
//   undefined -> ADDR[1:0] ignored, FaultM tied 0
// ---------------------------------------------------------------------------
module dmem_wait_responder
  import dmem_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  dmem_wait_responder_if.slave bus
);

  localparam int               IDX_W    = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_INIT = (WAIT_CYCLES == 0) ? '0 : CNT_W'(WAIT_CYCLES - 1);

  state_t             r_state;
  state_t             w_nextState;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_nextCnt;
  logic               w_accept;
  logic               w_enterDone;
  logic               w_commit;

  logic               r_we;
  logic [IDX_W-1:0]   r_idx;
  logic [WIDTH-1:0]   r_wd;
  logic               r_fault;

  logic               w_fromIdle;
  logic               w_curWe;
  logic [IDX_W-1:0]   w_curIdx;
  logic [WIDTH-1:0]   w_curWd;
  logic               w_curFault;
  logic [WIDTH-1:0]   w_rdata;
  logic               w_unused;

  // Next-state and counter logic. With zero wait states the request goes
  // straight from IDLE to DONE, so the accept edge is also the commit edge.
  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_cnt;
    w_accept    = 1'b0;
    w_enterDone = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.ReqM) begin
          w_accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            w_nextState = S_DONE;
            w_enterDone = 1'b1;
          end else begin
            w_nextState = S_WAIT;
            w_nextCnt   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (r_cnt == '0) begin
          w_nextState = S_DONE;
          w_enterDone = 1'b1;
        end else begin
          w_nextCnt = r_cnt - 1'b1;
        end
      end
      S_DONE: begin
        w_nextState = S_IDLE;
      end
      default: begin
        w_nextState = S_IDLE;
      end
    endcase
  end

  // State register and fault flag. The fault flag is captured on the same
  // edge that enters DONE so it lines up with DoneM and keeps masking RD
  // until the next completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_cnt   <= w_nextCnt;
      if (w_enterDone) begin
        r_fault <= w_curFault;
      end
    end
  end

  // Request latch: captures the access at accept so the commit does not
  // depend on the pipeline keeping ADDR/WD steady.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_we  <= bus.WE;
      r_idx <= bus.ADDR[IDX_W+WORD_OFS-1:WORD_OFS];
      r_wd  <= bus.WD;
    end
  end

  // In the zero-wait case the commit happens while still in IDLE, before the
  // latch has been written, so the live bus values are used instead.
  assign w_fromIdle = (r_state == S_IDLE);
  assign w_curWe    = w_fromIdle ? bus.WE : r_we;
  assign w_curIdx   = w_fromIdle ? bus.ADDR[IDX_W+WORD_OFS-1:WORD_OFS] : r_idx;
  assign w_curWd    = w_fromIdle ? bus.WD : r_wd;

`ifdef DMEM_MISALIGN_FAULT_EN
  logic r_misalign;

  // Misalignment is judged on the address seen at accept.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_misalign <= (bus.ADDR[WORD_OFS-1:0] != '0);
    end
  end

  assign w_curFault = w_fromIdle ? (bus.ADDR[WORD_OFS-1:0] != '0) : r_misalign;
`else
  assign w_curFault = 1'b0;
`endif

  // A reset on the would-be DONE-entry edge must not let the write through.
  assign w_commit = w_enterDone & ~reset;

  dmem_array #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_array (
    .clk   (clk),
    .reset (reset),
    .we    (w_commit & w_curWe & ~w_curFault),
    .waddr (w_curIdx),
    .wdata (w_curWd),
    .re    (w_commit & ~w_curWe),
    .raddr (w_curIdx),
    .rdata (w_rdata)
  );

  assign bus.DoneM  = (r_state == S_DONE);
  assign bus.Busy   = (r_state != S_IDLE);
  assign bus.StallM = bus.ReqM & ~bus.DoneM;
  assign bus.FaultM = r_fault & bus.DoneM;
  assign bus.RD     = r_fault ? '0 : w_rdata;

  // Address bits outside the word index are intentionally ignored.
  assign w_unused = ^bus.ADDR;

endmodule

// File: tb/tb_dmem_wait_responder.sv
// ---------------------------------------------------------------------------
// tb_dmem_wait_responder
// Self-checking bench for dmem_wait_responder. Two instances are built:
// one with WAIT_CYCLES=2 and one with WAIT_CYCLES=0. A table of
// transactions is replayed through applyStimulus, followed by hand-written
// sequences for back-to-back issue, ReqM drop and reset during WAIT.
// Expected misalignment behaviour follows DMEM_MISALIGN_FAULT_EN.
// ---------------------------------------------------------------------------
module tb_dmem_wait_responder;

  logic clk;
  logic reset;
  int   testsRun;
  int   testsFailed;

`ifdef DMEM_MISALIGN_FAULT_EN
  localparam logic        EXP_FAULT   = 1'b1;
  localparam logic [31:0] WORD4_AFTER = 32'hDEADBEEF;
`else
  localparam logic        EXP_FAULT   = 1'b0;
  localparam logic [31:0] WORD4_AFTER = 32'hA5A5A5A5;
`endif

  typedef struct {
    int          waitSel;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        chkRd;
    logic [31:0] expRd;
    logic        expFault;
  } vec_t;

  dmem_wait_responder_if #(.WIDTH(32)) if2 ();
  dmem_wait_responder_if #(.WIDTH(32)) if0 ();

  dmem_wait_responder #(
    .WIDTH       (32),
    .DEPTH       (64),
    .WAIT_CYCLES (2)
  ) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (if2)
  );

  dmem_wait_responder #(
    .WIDTH       (32),
    .DEPTH       (64),
    .WAIT_CYCLES (0)
  ) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (if0)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Overall time limit so the bench can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] time limit reached");
  end

  function automatic logic getDone(input int w);
    return (w == 0) ? if0.DoneM : if2.DoneM;
  endfunction

  function automatic logic getStall(input int w);
    return (w == 0) ? if0.StallM : if2.StallM;
  endfunction

  function automatic logic getBusy(input int w);
    return (w == 0) ? if0.Busy : if2.Busy;
  endfunction

  function automatic logic getFault(input int w);
    return (w == 0) ? if0.FaultM : if2.FaultM;
  endfunction

  function automatic logic [31:0] getRd(input int w);
    return (w == 0) ? if0.RD : if2.RD;
  endfunction

  function automatic vec_t mk(input int w, input logic we, input logic [31:0] addr,
                              input logic [31:0] wd, input logic chkRd,
                              input logic [31:0] expRd, input logic expFault);
    vec_t v;
    v.waitSel  = w;
    v.we       = we;
    v.addr     = addr;
    v.wd       = wd;
    v.chkRd    = chkRd;
    v.expRd    = expRd;
    v.expFault = expFault;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic driveReq(input int w, input logic req, input logic we,
                          input logic [31:0] addr, input logic [31:0] wd);
    if (w == 0) begin
      if0.ReqM = req;
      if0.WE   = we;
      if0.ADDR = addr;
      if0.WD   = wd;
    end else begin
      if2.ReqM = req;
      if2.WE   = we;
      if2.ADDR = addr;
      if2.WD   = wd;
    end
  endtask

  // One complete access: request held until DoneM, then dropped. Checks
  // stall from the first cycle, latency, stall length, done outputs and the
  // return to idle. Starts and ends 1 time unit after a rising edge.
  task automatic applyStimulus(input vec_t v);
    int   edges;
    int   stalls;
    logic seen;
    driveReq(v.waitSel, 1'b1, v.we, v.addr, v.wd);
    #1;
    checkOutput("preStall", 32'(getStall(v.waitSel)), 32'd1);
    checkOutput("preBusy", 32'(getBusy(v.waitSel)), 32'd0);
    stalls = getStall(v.waitSel) ? 1 : 0;
    edges  = 0;
    seen   = 1'b0;
    while (!seen && edges < 10) begin
      @(posedge clk);
      #1;
      edges++;
      if (getDone(v.waitSel)) seen = 1'b1;
      else if (getStall(v.waitSel)) stalls++;
    end
    checkOutput("doneSeen", 32'(seen), 32'd1);
    checkOutput("latency", 32'(edges), 32'(v.waitSel + 1));
    checkOutput("stallCycles", 32'(stalls), 32'(v.waitSel + 1));
    checkOutput("stallAtDone", 32'(getStall(v.waitSel)), 32'd0);
    checkOutput("busyAtDone", 32'(getBusy(v.waitSel)), 32'd1);
    checkOutput("fault", 32'(getFault(v.waitSel)), 32'(v.expFault));
    if (v.chkRd) checkOutput("rdAtDone", getRd(v.waitSel), v.expRd);
    driveReq(v.waitSel, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    checkOutput("donePulse", 32'(getDone(v.waitSel)), 32'd0);
    checkOutput("idleBusy", 32'(getBusy(v.waitSel)), 32'd0);
    if (v.chkRd) checkOutput("rdHold", getRd(v.waitSel), v.expRd);
  endtask

  initial begin
    vec_t vecs[14];
    int   donePulses;

    testsRun    = 0;
    testsFailed = 0;

    vecs[0]  = mk(2, 1'b1, 32'h0000_0010, 32'hDEADBEEF, 1'b0, 32'h0,        1'b0);
    vecs[1]  = mk(2, 1'b0, 32'h0000_0010, 32'h0,        1'b1, 32'hDEADBEEF, 1'b0);
    vecs[2]  = mk(2, 1'b1, 32'h0000_0100, 32'h0000_0055, 1'b0, 32'h0,       1'b0);
    vecs[3]  = mk(2, 1'b0, 32'h0000_0000, 32'h0,        1'b1, 32'h0000_0055, 1'b0);
    vecs[4]  = mk(2, 1'b0, 32'h0000_0010, 32'h0,        1'b1, 32'hDEADBEEF, 1'b0);
    vecs[5]  = mk(2, 1'b1, 32'h0000_0020, 32'h0BADCAFE, 1'b0, 32'h0,        1'b0);
    vecs[6]  = mk(2, 1'b0, 32'h0000_0020, 32'h0,        1'b1, 32'h0BADCAFE, 1'b0);
    vecs[7]  = mk(2, 1'b1, 32'h0000_0013, 32'hA5A5A5A5, 1'b0, 32'h0,        EXP_FAULT);
    vecs[8]  = mk(2, 1'b0, 32'h0000_0010, 32'h0,        1'b1, WORD4_AFTER,  1'b0);
    vecs[9]  = mk(2, 1'b1, 32'h1234_0024, 32'hCAFEF00D, 1'b0, 32'h0,        1'b0);
    vecs[10] = mk(2, 1'b0, 32'h0000_0024, 32'h0,        1'b1, 32'hCAFEF00D, 1'b0);
    vecs[11] = mk(0, 1'b1, 32'h0000_0004, 32'h11112222, 1'b0, 32'h0,        1'b0);
    vecs[12] = mk(0, 1'b1, 32'h0000_0008, 32'h33334444, 1'b0, 32'h0,        1'b0);
    vecs[13] = mk(0, 1'b0, 32'h0000_0004, 32'h0,        1'b1, 32'h11112222, 1'b0);

    reset = 1'b1;
    driveReq(2, 1'b0, 1'b0, 32'h0, 32'h0);
    driveReq(0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rstRd", if2.RD, 32'h0);
    checkOutput("rstDone", 32'(if2.DoneM), 32'd0);
    checkOutput("rstBusy", 32'(if2.Busy), 32'd0);
    checkOutput("rstFault", 32'(if2.FaultM), 32'd0);
    checkOutput("rstStall", 32'(if2.StallM), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i]);
    end

    // Back-to-back loads on the zero-wait instance: second accept two
    // cycles after the first.
    driveReq(0, 1'b1, 1'b0, 32'h0000_0004, 32'h0);
    #1;
    checkOutput("b2bStall0", 32'(if0.StallM), 32'd1);
    @(posedge clk);
    #1;
    checkOutput("b2bDone1", 32'(if0.DoneM), 32'd1);
    checkOutput("b2bRd1", if0.RD, 32'h11112222);
    driveReq(0, 1'b1, 1'b0, 32'h0000_0008, 32'h0);
    @(posedge clk);
    #1;
    checkOutput("b2bGap", 32'(if0.DoneM), 32'd0);
    checkOutput("b2bStallGap", 32'(if0.StallM), 32'd1);
    @(posedge clk);
    #1;
    checkOutput("b2bDone2", 32'(if0.DoneM), 32'd1);
    checkOutput("b2bRd2", if0.RD, 32'h33334444);
    driveReq(0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    checkOutput("b2bIdle", 32'(if0.Busy), 32'd0);

    // ReqM dropped during WAIT: exactly one done pulse, no re-accept.
    driveReq(2, 1'b1, 1'b0, 32'h0000_0020, 32'h0);
    @(posedge clk);
    #1;
    driveReq(2, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    checkOutput("dropStall", 32'(if2.StallM), 32'd0);
    checkOutput("dropBusy", 32'(if2.Busy), 32'd1);
    donePulses = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      if (if2.DoneM) begin
        donePulses++;
        checkOutput("dropRd", if2.RD, 32'h0BADCAFE);
      end
    end
    checkOutput("dropPulses", 32'(donePulses), 32'd1);
    checkOutput("dropIdle", 32'(if2.Busy), 32'd0);

    // Reset on the edge that would have entered DONE: store must be lost.
    driveReq(2, 1'b1, 1'b1, 32'h0000_0020, 32'h0000_1234);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    checkOutput("abortBusy", 32'(if2.Busy), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    driveReq(2, 1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("abortIdle", 32'(if2.Busy), 32'd0);
    checkOutput("abortRd", if2.RD, 32'h0);
    donePulses = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      if (if2.DoneM) donePulses++;
    end
    checkOutput("abortPulses", 32'(donePulses), 32'd0);
    applyStimulus(mk(2, 1'b0, 32'h0000_0020, 32'h0, 1'b1, 32'h0BADCAFE, 1'b0));

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
